// File: rtl/pass_check_ctrl.sv
// Password-verification controller: collects entered digits, fetches the stored password
// from a fixed-latency ROM, compares, and tracks attempts. Optional lockout: PASS_LOCKOUT_EN.
module pass_check_ctrl #(
  parameter int DIGIT_W      = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int ID_W         = 5,
  parameter int ADDR_W       = 7,
  parameter int ROM_LAT      = 2,
  parameter int MAX_ATTEMPTS = 3
`ifdef PASS_LOCKOUT_EN
  , parameter int LOCKOUT_CYCLES = 1024
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                game_enter,
  input  logic [DIGIT_W-1:0]                  user_digit,
  input  logic                                matched_id,
  input  logic [ID_W-1:0]                     internal_id,
  input  logic                                guest,
  input  logic                                gc_logout,
  output logic [ADDR_W-1:0]                   rom_addr,
  input  logic [DIGIT_W-1:0]                  rom_data,
  output logic                                log_in,
  output logic                                log_out,
  output logic                                fail_pulse,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
`ifdef PASS_LOCKOUT_EN
  output logic                                locked,
`endif
  output logic [3:0]                          state_dbg
);

  localparam int SR_W   = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
`ifdef PASS_LOCKOUT_EN
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
`endif

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    COLLECT  = 4'd1,
    FETCH    = 4'd2,
    WAIT_ROM = 4'd3,
    CATCH    = 4'd4,
    COMPARE  = 4'd5,
    PASSED   = 4'd6,
    LOCKOUT  = 4'd7
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     digit_sr_q, digit_sr_d;
  logic [SR_W-1:0]     rom_sr_q, rom_sr_d;
  logic [CNT_W-1:0]    dcnt_q, dcnt_d;
  logic [CNT_W-1:0]    kcnt_q, kcnt_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [ATT_W-1:0]    att_d;
  logic                log_in_d, log_out_d, fail_d;
  logic [ADDR_W-1:0]   base_addr;
`ifdef PASS_LOCKOUT_EN
  logic [LOCK_W-1:0]   lock_q, lock_d;
  assign locked = (state_q == LOCKOUT);
`endif

  assign state_dbg = state_q;
  assign base_addr = ADDR_W'(id_q) * ADDR_W'(NUM_DIGITS);

  // ROM contract: rom_addr is registered and stays put in FETCH/WAIT_ROM; rom_data is
  // taken in CATCH, exactly ROM_LAT cycles after the address first appeared.
  always_comb begin
    state_d    = state_q;
    digit_sr_d = digit_sr_q;
    rom_sr_d   = rom_sr_q;
    dcnt_d     = dcnt_q;
    kcnt_d     = kcnt_q;
    wcnt_d     = wcnt_q;
    id_d       = id_q;
    addr_d     = rom_addr;
    att_d      = attempts_left;
    log_in_d   = 1'b0;
    log_out_d  = 1'b0;
    fail_d     = 1'b0;
`ifdef PASS_LOCKOUT_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (guest) begin
          state_d = PASSED;
        end else if (matched_id) begin
          state_d = COLLECT;
          id_d    = internal_id;
        end
      end
      COLLECT: begin
        if (!matched_id) begin
          state_d    = IDLE;
          digit_sr_d = '0;
          dcnt_d     = '0;
        end else if (game_enter) begin
          digit_sr_d = (digit_sr_q << DIGIT_W) | SR_W'(user_digit);
          if (dcnt_q == CNT_W'(NUM_DIGITS - 1)) begin
            state_d = FETCH;
            dcnt_d  = '0;
            kcnt_d  = '0;
            addr_d  = base_addr;
          end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
          end
        end
      end
      FETCH: begin
        if (ROM_LAT > 1) begin
          state_d = WAIT_ROM;
          wcnt_d  = WAIT_W'(ROM_LAT - 2);
        end else begin
          state_d = CATCH;
        end
      end
      WAIT_ROM: begin
        if (wcnt_q == '0) state_d = CATCH;
        else              wcnt_d  = wcnt_q - WAIT_W'(1);
      end
      CATCH: begin
        rom_sr_d = (rom_sr_q << DIGIT_W) | SR_W'(rom_data);
        if (kcnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          state_d = COMPARE;
        end else begin
          state_d = FETCH;
          kcnt_d  = kcnt_q + CNT_W'(1);
          addr_d  = base_addr + ADDR_W'(kcnt_q) + ADDR_W'(1);
        end
      end
      COMPARE: begin
        digit_sr_d = '0;
        if (digit_sr_q == rom_sr_q) begin
          state_d = PASSED;
          att_d   = ATT_W'(MAX_ATTEMPTS);
        end else begin
          fail_d = 1'b1;
          if (attempts_left == ATT_W'(1)) begin
            log_out_d = 1'b1;
            att_d     = ATT_W'(MAX_ATTEMPTS);
`ifdef PASS_LOCKOUT_EN
            state_d   = LOCKOUT;
            lock_d    = LOCK_W'(LOCKOUT_CYCLES - 1);
`else
            state_d   = IDLE;
`endif
          end else begin
            att_d   = attempts_left - ATT_W'(1);
            state_d = COLLECT;
          end
        end
      end
      PASSED: begin
        if (gc_logout) begin
          log_out_d = 1'b1;
          state_d   = IDLE;
        end else begin
          log_in_d = 1'b1;
        end
      end
`ifdef PASS_LOCKOUT_EN
      LOCKOUT: begin
        if (lock_q == '0) state_d = IDLE;
        else              lock_d  = lock_q - LOCK_W'(1);
      end
`endif
      default: begin
        state_d    = IDLE;
        digit_sr_d = '0;
        rom_sr_d   = '0;
        dcnt_d     = '0;
        kcnt_d     = '0;
        wcnt_d     = '0;
        id_d       = '0;
        addr_d     = '0;
        att_d      = ATT_W'(MAX_ATTEMPTS);
`ifdef PASS_LOCKOUT_EN
        lock_d     = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      digit_sr_q    <= '0;
      rom_sr_q      <= '0;
      dcnt_q        <= '0;
      kcnt_q        <= '0;
      wcnt_q        <= '0;
      id_q          <= '0;
      rom_addr      <= '0;
      attempts_left <= ATT_W'(MAX_ATTEMPTS);
      log_in        <= 1'b0;
      log_out       <= 1'b0;
      fail_pulse    <= 1'b0;
`ifdef PASS_LOCKOUT_EN
      lock_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      digit_sr_q    <= digit_sr_d;
      rom_sr_q      <= rom_sr_d;
      dcnt_q        <= dcnt_d;
      kcnt_q        <= kcnt_d;
      wcnt_q        <= wcnt_d;
      id_q          <= id_d;
      rom_addr      <= addr_d;
      attempts_left <= att_d;
      log_in        <= log_in_d;
      log_out       <= log_out_d;
      fail_pulse    <= fail_d;
`ifdef PASS_LOCKOUT_EN
      lock_q        <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_pass_check_ctrl.sv
// Directed bench for pass_check_ctrl: login, failures, guest, abort, async reset, lockout.
module tb_pass_check_ctrl;

  localparam int ROM_LAT = 2;
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_COLLECT = 4'd1;
  localparam logic [3:0] S_FETCH   = 4'd2;
  localparam logic [3:0] S_WAIT    = 4'd3;
  localparam logic [3:0] S_PASSED  = 4'd6;
  localparam logic [3:0] S_LOCKOUT = 4'd7;
  // log_in rises this many negedge samples after the 4th digit's sampling edge (c=1 is first)
  localparam int LOGIN_C = 4 * (ROM_LAT + 1) + 2 + 1;
  localparam int FAIL_C  = 4 * (ROM_LAT + 1) + 1 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_enter = 1'b0;
  logic [3:0] user_digit = '0;
  logic       matched_id = 1'b0;
  logic [4:0] internal_id = '0;
  logic       guest = 1'b0;
  logic       gc_logout = 1'b0;
  logic [6:0] rom_addr;
  logic [3:0] rom_data;
  logic       log_in, log_out, fail_pulse;
  logic [1:0] attempts_left;
  logic [3:0] state_dbg;
`ifdef PASS_LOCKOUT_EN
  logic       locked;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pass_check_ctrl #(
    .DIGIT_W(4), .NUM_DIGITS(4), .ID_W(5), .ADDR_W(7), .ROM_LAT(ROM_LAT), .MAX_ATTEMPTS(3)
`ifdef PASS_LOCKOUT_EN
    , .LOCKOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .game_enter(game_enter), .user_digit(user_digit),
    .matched_id(matched_id), .internal_id(internal_id), .guest(guest),
    .gc_logout(gc_logout), .rom_addr(rom_addr), .rom_data(rom_data),
    .log_in(log_in), .log_out(log_out), .fail_pulse(fail_pulse),
    .attempts_left(attempts_left),
`ifdef PASS_LOCKOUT_EN
    .locked(locked),
`endif
    .state_dbg(state_dbg)
  );

  // Synchronous ROM model with ROM_LAT register stages
  logic [3:0] rom_mem [0:127];
  logic [3:0] rom_pipe [0:ROM_LAT-1];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_mem[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 4'(i ^ 5);
    rom_mem[12] = 4'h1;
    rom_mem[13] = 4'h2;
    rom_mem[14] = 4'h3;
    rom_mem[15] = 4'h4;
  end

  // Driver: enter four digits, first digit in pw[15:12]; returns at the negedge after the 4th edge
  task automatic enter_pw(input logic [15:0] pw);
    for (int i = 0; i < 4; i++) begin
      game_enter = 1'b1;
      user_digit = pw[15-4*i -: 4];
      @(negedge clk);
      game_enter = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (log_in !== 1'b0) begin n_fail++; $display("FAIL reset_log_in got %b exp 0", log_in); end
    n_tests++; if (log_out !== 1'b0) begin n_fail++; $display("FAIL reset_log_out got %b exp 0", log_out); end
    n_tests++; if (fail_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_fail got %b exp 0", fail_pulse); end
    n_tests++; if (rom_addr !== 7'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); end
    n_tests++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL reset_attempts got %0d exp 3", attempts_left); end
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", state_dbg, S_IDLE); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_guest();
    guest = 1'b1; matched_id = 1'b1; internal_id = 5'd3;
    @(negedge clk);
    guest = 1'b0; matched_id = 1'b0;
    n_tests++; if (state_dbg !== S_PASSED) begin n_fail++; $display("FAIL guest_state got %0d exp %0d", state_dbg, S_PASSED); end
    n_tests++; if (log_in !== 1'b0) begin n_fail++; $display("FAIL guest_log_in_entry got %b exp 0", log_in); end
    @(negedge clk);
    n_tests++; if (log_in !== 1'b1) begin n_fail++; $display("FAIL guest_log_in got %b exp 1", log_in); end
    n_tests++; if (rom_addr !== 7'd0) begin n_fail++; $display("FAIL guest_rom_addr got %0d exp 0", rom_addr); end
    gc_logout = 1'b1;
    @(negedge clk);
    gc_logout = 1'b0;
    n_tests++; if (log_in !== 1'b0) begin n_fail++; $display("FAIL guest_logout_log_in got %b exp 0", log_in); end
    n_tests++; if (log_out !== 1'b1) begin n_fail++; $display("FAIL guest_log_out got %b exp 1", log_out); end
    @(negedge clk);
    n_tests++; if (log_out !== 1'b0) begin n_fail++; $display("FAIL guest_log_out_width got %b exp 0", log_out); end
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL guest_end_state got %0d exp %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_login();
    int first_in;
    matched_id = 1'b1; internal_id = 5'd3;
    @(negedge clk);
    n_tests++; if (state_dbg !== S_COLLECT) begin n_fail++; $display("FAIL login_collect got %0d exp %0d", state_dbg, S_COLLECT); end
    enter_pw(16'h1234);
    first_in = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1 || c == 4 || c == 7 || c == 10) begin
        n_tests++;
        if (rom_addr !== 7'(12 + (c - 1) / 3)) begin
          n_fail++; $display("FAIL login_rom_addr c=%0d got %0d exp %0d", c, rom_addr, 12 + (c - 1) / 3);
        end
      end
      if (c == 1) begin
        n_tests++; if (state_dbg !== S_FETCH) begin n_fail++; $display("FAIL login_fetch got %0d exp %0d", state_dbg, S_FETCH); end
      end
      if (c == 2) begin
        n_tests++; if (state_dbg !== S_WAIT) begin n_fail++; $display("FAIL login_wait got %0d exp %0d", state_dbg, S_WAIT); end
      end
      if (log_in === 1'b1) begin
        first_in = c;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (first_in != LOGIN_C) begin n_fail++; $display("FAIL login_latency got %0d exp %0d", first_in, LOGIN_C); end
    n_tests++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL login_attempts got %0d exp 3", attempts_left); end
    gc_logout = 1'b1; matched_id = 1'b0;
    @(negedge clk);
    gc_logout = 1'b0;
    n_tests++; if (log_out !== 1'b1 || log_in !== 1'b0) begin n_fail++; $display("FAIL login_logout got out=%b in=%b exp out=1 in=0", log_out, log_in); end
    @(negedge clk);
    n_tests++; if (log_out !== 1'b0) begin n_fail++; $display("FAIL login_log_out_width got %b exp 0", log_out); end
  endtask

  task automatic test_fail();
    int fail_at, logins;
    logic [1:0] exp_att;
    logic       exp_lo;
    logic [3:0] exp_st;
    matched_id = 1'b1; internal_id = 5'd3;
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      exp_att = (a == 0) ? 2'd2 : (a == 1) ? 2'd1 : 2'd3;
      exp_lo  = (a == 2);
`ifdef PASS_LOCKOUT_EN
      exp_st  = (a == 2) ? S_LOCKOUT : S_COLLECT;
`else
      exp_st  = (a == 2) ? S_IDLE : S_COLLECT;
`endif
      enter_pw(16'h1235);
      fail_at = -1; logins = 0;
      for (int c = 1; c <= 30; c++) begin
        if (log_in === 1'b1) logins++;
        if (fail_pulse === 1'b1) begin
          fail_at = c;
          break;
        end
        @(negedge clk);
      end
      n_tests++; if (fail_at != FAIL_C) begin n_fail++; $display("FAIL fail_pulse_time a=%0d got %0d exp %0d", a, fail_at, FAIL_C); end
      n_tests++; if (attempts_left !== exp_att) begin n_fail++; $display("FAIL fail_attempts a=%0d got %0d exp %0d", a, attempts_left, exp_att); end
      n_tests++; if (log_out !== exp_lo) begin n_fail++; $display("FAIL fail_log_out a=%0d got %b exp %b", a, log_out, exp_lo); end
      n_tests++; if (state_dbg !== exp_st) begin n_fail++; $display("FAIL fail_state a=%0d got %0d exp %0d", a, state_dbg, exp_st); end
      n_tests++; if (logins != 0 || log_in !== 1'b0) begin n_fail++; $display("FAIL fail_log_in a=%0d got %0d highs exp 0", a, logins); end
    end
    matched_id = 1'b0;
    @(negedge clk);
    n_tests++; if (fail_pulse !== 1'b0 || log_out !== 1'b0) begin n_fail++; $display("FAIL fail_pulse_width got fail=%b out=%b exp 0 0", fail_pulse, log_out); end
`ifdef PASS_LOCKOUT_EN
    repeat (20) @(negedge clk);
`endif
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL fail_end_state got %0d exp %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_abort();
    int first_in;
    matched_id = 1'b1; internal_id = 5'd3;
    @(negedge clk);
    game_enter = 1'b1; user_digit = 4'h1; @(negedge clk);
    user_digit = 4'h2; @(negedge clk);
    game_enter = 1'b0; matched_id = 1'b0;
    @(negedge clk);
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL abort_state got %0d exp %0d", state_dbg, S_IDLE); end
    n_tests++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL abort_attempts got %0d exp 3", attempts_left); end
    matched_id = 1'b1;
    @(negedge clk);
    enter_pw(16'h1234);
    first_in = -1;
    for (int c = 1; c <= 30; c++) begin
      if (log_in === 1'b1) begin
        first_in = c;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (first_in != LOGIN_C) begin n_fail++; $display("FAIL abort_relogin got %0d exp %0d", first_in, LOGIN_C); end
    n_tests++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL abort_relogin_attempts got %0d exp 3", attempts_left); end
    gc_logout = 1'b1; matched_id = 1'b0;
    @(negedge clk);
    gc_logout = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int seen;
    matched_id = 1'b1; internal_id = 5'd3;
    @(negedge clk);
    enter_pw(16'h9999);
    seen = 0;
    for (int c = 1; c <= 30; c++) begin
      if (fail_pulse === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (seen != 1 || attempts_left !== 2'd2) begin n_fail++; $display("FAIL arst_pre_attempts got %0d exp 2", attempts_left); end
    enter_pw(16'h1234);
    @(negedge clk);
    n_tests++; if (state_dbg !== S_WAIT) begin n_fail++; $display("FAIL arst_in_wait got %0d exp %0d", state_dbg, S_WAIT); end
    #2 rst = 1'b0; matched_id = 1'b0;
    #1;
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL arst_wait_state got %0d exp %0d", state_dbg, S_IDLE); end
    n_tests++; if (rom_addr !== 7'd0) begin n_fail++; $display("FAIL arst_wait_rom_addr got %0d exp 0", rom_addr); end
    n_tests++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL arst_wait_attempts got %0d exp 3", attempts_left); end
    @(negedge clk);
    rst = 1'b1;
    guest = 1'b1;
    @(negedge clk);
    guest = 1'b0;
    @(negedge clk);
    n_tests++; if (log_in !== 1'b1) begin n_fail++; $display("FAIL arst_pre_passed got %b exp 1", log_in); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (log_in !== 1'b0 || log_out !== 1'b0) begin n_fail++; $display("FAIL arst_passed got in=%b out=%b exp 0 0", log_in, log_out); end
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL arst_passed_state got %0d exp %0d", state_dbg, S_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (log_out !== 1'b0 || log_in !== 1'b0) begin n_fail++; $display("FAIL arst_release got in=%b out=%b exp 0 0", log_in, log_out); end
  endtask

`ifdef PASS_LOCKOUT_EN
  task automatic test_lockout();
    int lock_cycles, first_in;
    matched_id = 1'b1; internal_id = 5'd3;
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      enter_pw(16'h1235);
      for (int c = 1; c <= 30; c++) begin
        if (fail_pulse === 1'b1) break;
        @(negedge clk);
      end
    end
    lock_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (locked !== 1'b1) break;
      lock_cycles++;
      if (state_dbg !== S_LOCKOUT) begin n_tests++; n_fail++; $display("FAIL lock_state got %0d exp %0d", state_dbg, S_LOCKOUT); end
      @(negedge clk);
    end
    n_tests++; if (lock_cycles != 16) begin n_fail++; $display("FAIL lock_cycles got %0d exp 16", lock_cycles); end
    n_tests++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL lock_exit_state got %0d exp %0d", state_dbg, S_IDLE); end
    @(negedge clk);
    enter_pw(16'h1234);
    first_in = -1;
    for (int c = 1; c <= 30; c++) begin
      if (log_in === 1'b1) begin
        first_in = c;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (first_in != LOGIN_C) begin n_fail++; $display("FAIL lock_relogin got %0d exp %0d", first_in, LOGIN_C); end
    gc_logout = 1'b1; matched_id = 1'b0;
    @(negedge clk);
    gc_logout = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_guest();
    test_login();
    test_fail();
    test_abort();
    test_async_reset();
`ifdef PASS_LOCKOUT_EN
    test_lockout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pass_check_ctrl.md
Name: pass_check_ctrl

Overview:
Parametrised password-verification controller for the MU authentication path. After the user-ID stage asserts matched_id, it collects NUM_DIGITS entered digits and fetches the stored password for the matched user from an external synchronous password ROM of configurable latency. It compares the two, counts failed attempts up to MAX_ATTEMPTS, and holds log_in until the game controller requests logout. Guest entry bypasses the check.

Parameters:
DIGIT_W, 4, bits per password digit
NUM_DIGITS, 4, digits per password
ID_W, 5, width of internal_id
ADDR_W, 7, ROM address width; must satisfy 2^ADDR_W >= 2^ID_W*NUM_DIGITS
ROM_LAT, 2, cycles from rom_addr valid to rom_data valid (>=1)
MAX_ATTEMPTS, 3, failed compares before forced logout (>=1)
LOCKOUT_CYCLES, 1024, lockout duration after forced logout (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
game_enter  in  1  one-cycle digit-entry strobe
user_digit  in  DIGIT_W  digit sampled on game_enter
matched_id  in  1  level; user-ID stage has matched
internal_id  in  ID_W  index of matched user
guest  in  1  level; guest login request
gc_logout  in  1  game-controller logout request
rom_addr  out  ADDR_W  password ROM address
rom_data  in  DIGIT_W  password ROM data
log_in  out  1  level; session authenticated
log_out  out  1  one-cycle logout pulse
fail_pulse  out  1  one-cycle pulse per failed compare
attempts_left  out  $clog2(MAX_ATTEMPTS+1)  remaining attempts

Behaviour:
- Reset: state=IDLE; log_in=0, log_out=0, fail_pulse=0, rom_addr=0, attempts_left=MAX_ATTEMPTS. Digit/ROM shift registers, counters and the latched ID are cleared.
- Shift registers are NUM_DIGITS*DIGIT_W bits, shifted left by DIGIT_W with the new digit in the LSBs, so the first digit entered ends up most significant.
- IDLE: guest=1 -> PASSED (guest has priority over matched_id). Else matched_id=1 -> COLLECT, latching internal_id.
- COLLECT: each game_enter shifts user_digit in. On the NUM_DIGITS-th digit -> FETCH, and the digit counter returns to 0. If matched_id drops before that -> IDLE, clearing collected digits; attempts are kept.
- FETCH: drive rom_addr = latched_id*NUM_DIGITS + k, with k = 0..NUM_DIGITS-1. Wait ROM_LAT cycles (WAIT_ROM), then CATCH shifts rom_data in. k = NUM_DIGITS-1 -> COMPARE, else k+1 -> FETCH. Fetch latency is NUM_DIGITS*(ROM_LAT+1) cycles. game_enter is ignored from FETCH through COMPARE.
- COMPARE, on match: -> PASSED; attempts_left reloads to MAX_ATTEMPTS.
- COMPARE, on mismatch: fail_pulse=1 for one cycle and attempts_left decrements.
  - If attempts_left becomes 0: log_out pulses for one cycle, attempts_left reloads, -> IDLE (or LOCKOUT with the feature).
  - Otherwise: -> COLLECT with the digit register cleared.
- PASSED: log_in=1 from the cycle after entry. gc_logout=1 gives log_in=0 and a one-cycle log_out pulse in the same clock edge, then -> IDLE. gc_logout is sampled only in PASSED.
- Any illegal state: return to IDLE with reset values.
- Asynchronous reset mid-operation (including mid-fetch or PASSED) drops log_in immediately. No log_out pulse is produced.

Optional Feature:
Macro PASS_LOCKOUT_EN.
- Defined: the forced logout goes to LOCKOUT. A down-counter loads LOCKOUT_CYCLES-1 and guest/matched_id are ignored until it reaches 0, then -> IDLE. A 1-bit output locked is added, high only while in LOCKOUT.
- Undefined: no counter, no locked port; forced logout goes directly to IDLE.

Test Plan:
- ROM id 3 holds 4'h1,2,3,4 (addresses 12..15). matched_id=1, internal_id=3, digits 1,2,3,4 -> rom_addr sequences 12,13,14,15; log_in=1 exactly 4*(ROM_LAT+1)+2 cycles after the 4th game_enter.
- Same ROM, enter 1,2,3,5 three times -> fail_pulse three times; attempts_left 2,1 then reload to 3; single log_out pulse after the 3rd failure; state IDLE; log_in stays 0.
- guest=1 and matched_id=1 together in IDLE -> PASSED with no ROM access (rom_addr stays 0); gc_logout=1 for one cycle -> log_in=0, log_out pulses once.
- Two digits entered, matched_id drops -> IDLE. Re-enter the full correct password -> login succeeds; attempts_left unchanged at 3 throughout.
- Assert rst=0 while in WAIT_ROM and separately while in PASSED -> all outputs at reset values asynchronously, no log_out pulse.
- With PASS_LOCKOUT_EN and LOCKOUT_CYCLES=16: three failures -> locked=1 for 16 cycles, matched_id ignored during lockout, then IDLE and a correct entry logs in.
